// File: rtl/rand_seq_pkg.sv
// Shared definition of the team's 11-entry 4-bit pseudo-random sequence.
// Both the counter and the checker take the sequence and its helpers from here.
package rand_seq_pkg;

  localparam int SEQ_LEN = 11;

  // Entry 0 is the rightmost element: 1,7,11,4,9,2,5,12,6,3,15.
  localparam logic [SEQ_LEN-1:0][3:0] SEQ_TABLE = {
    4'd15, 4'd3, 4'd6, 4'd12, 4'd5, 4'd2, 4'd9, 4'd4, 4'd11, 4'd7, 4'd1
  };

  typedef enum logic [1:0] {
    StHunt,
    StVerify,
    StLocked
  } state_e;

  function automatic logic seq_legal(input logic [3:0] v);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (SEQ_TABLE[i[3:0]] == v) ok = 1'b1;
    end
    return ok;
  endfunction

  // Position of v in the sequence; 0 for illegal values.
  function automatic logic [3:0] seq_idx(input logic [3:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (SEQ_TABLE[i[3:0]] == v) idx = i[3:0];
    end
    return idx;
  endfunction

  function automatic logic [3:0] seq_idx_inc(input logic [3:0] idx);
    return (idx >= 4'(SEQ_LEN - 1)) ? 4'd0 : idx + 4'd1;
  endfunction

  function automatic logic [3:0] seq_at(input logic [3:0] idx);
    return (idx < 4'(SEQ_LEN)) ? SEQ_TABLE[idx] : 4'd0;
  endfunction

  // Successor of v; 0 for illegal values.
  function automatic logic [3:0] seq_next(input logic [3:0] v);
    return seq_legal(v) ? seq_at(seq_idx_inc(seq_idx(v))) : 4'd0;
  endfunction

endpackage

// File: rtl/rand_seq_lut.sv
// Combinational classifier: 4-bit value -> legality, sequence position and successor.
module rand_seq_lut
  import rand_seq_pkg::*;
(
  input  logic [3:0] value_i,
  output logic       legal_o,
  output logic [3:0] idx_o,
  output logic [3:0] next_o
);

  always_comb begin
    legal_o = seq_legal(value_i);
    idx_o   = seq_idx(value_i);
    next_o  = seq_next(value_i);
  end

endmodule

// File: rtl/random_sequence_checker.sv
// Hunts for and locks onto the pseudo-random sequence, reporting position and
// counting mismatches once locked. All outputs are registered.
module random_sequence_checker
  import rand_seq_pkg::*;
#(
  parameter int unsigned LOCK_MATCHES = 3,
  parameter int unsigned LOSS_ERRORS  = 2,
  parameter int unsigned ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [3:0]           in_data,
  input  logic                 clear_err,
  output logic                 locked,
  output logic [3:0]           seq_index,
  output logic [3:0]           expected,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [3:0] LockMatches = 4'(LOCK_MATCHES);
  localparam logic [3:0] LossErrors  = 4'(LOSS_ERRORS);

  state_e               state_q, state_d;
  logic [3:0]           run_q, run_d;
  logic [3:0]           miss_q, miss_d;
  logic                 locked_q, locked_d;
  logic [3:0]           seq_index_q, seq_index_d;
  logic [3:0]           expected_q, expected_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic       lut_legal;
  logic [3:0] lut_idx;
  logic [3:0] lut_next;
  logic       count_err;

  rand_seq_lut u_lut (
    .value_i (in_data),
    .legal_o (lut_legal),
    .idx_o   (lut_idx),
    .next_o  (lut_next)
  );

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    miss_d      = miss_q;
    locked_d    = locked_q;
    seq_index_d = seq_index_q;
    expected_d  = expected_q;
    err_d       = 1'b0;
    count_err   = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        StHunt: begin
          if (lut_legal) begin
            run_d      = 4'd1;
            expected_d = lut_next;
            if (LockMatches == 4'd1) begin
              state_d     = StLocked;
              locked_d    = 1'b1;
              seq_index_d = lut_idx;
              miss_d      = 4'd0;
            end else begin
              state_d = StVerify;
            end
          end
        end
        StVerify: begin
          if (!lut_legal) begin
            state_d    = StHunt;
            run_d      = 4'd0;
            expected_d = 4'd0;
          end else if (in_data == expected_q) begin
            run_d      = run_q + 4'd1;
            expected_d = lut_next;
            if (run_q + 4'd1 >= LockMatches) begin
              state_d     = StLocked;
              locked_d    = 1'b1;
              seq_index_d = lut_idx;
              miss_d      = 4'd0;
            end
          end else begin
            run_d      = 4'd1;
            expected_d = lut_next;
          end
        end
        StLocked: begin
          if (in_data == expected_q) begin
            seq_index_d = lut_idx;
            expected_d  = lut_next;
            miss_d      = 4'd0;
          end else begin
            err_d     = 1'b1;
            count_err = 1'b1;
            if (miss_q + 4'd1 >= LossErrors) begin
              state_d     = StHunt;
              locked_d    = 1'b0;
              seq_index_d = 4'd0;
              expected_d  = 4'd0;
              miss_d      = 4'd0;
              run_d       = 4'd0;
            end else begin
              // Flywheel: assume the slot was consumed and keep tracking position.
              miss_d      = miss_q + 4'd1;
              seq_index_d = seq_idx_inc(seq_index_q);
              expected_d  = seq_next(expected_q);
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end

    err_count_d = err_count_q;
    if (clear_err) begin
      err_count_d = count_err ? ERR_CNT_W'(1) : '0;
    end else if (count_err && (err_count_q != {ERR_CNT_W{1'b1}})) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StHunt;
      run_q       <= 4'd0;
      miss_q      <= 4'd0;
      locked_q    <= 1'b0;
      seq_index_q <= 4'd0;
      expected_q  <= 4'd0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      seq_index_q <= seq_index_d;
      expected_q  <= expected_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign seq_index = seq_index_q;
  assign expected  = expected_q;
  assign err       = err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_random_sequence_checker.sv
// Bench for random_sequence_checker: two configurations driven by one stream,
// checked every cycle against a sequence-level model plus directed literals.
module tb_random_sequence_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [3:0] in_data;
  logic       clear_err;

  logic       locked_a, err_a;
  logic [3:0] seq_index_a, expected_a;
  logic [7:0] err_count_a;

  logic       locked_b, err_b;
  logic [3:0] seq_index_b, expected_b;
  logic [1:0] err_count_b;

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  random_sequence_checker u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clear_err (clear_err),
    .locked    (locked_a),
    .seq_index (seq_index_a),
    .expected  (expected_a),
    .err       (err_a),
    .err_count (err_count_a)
  );

  random_sequence_checker #(
    .LOCK_MATCHES (1),
    .LOSS_ERRORS  (15),
    .ERR_CNT_W    (2)
  ) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clear_err (clear_err),
    .locked    (locked_b),
    .seq_index (seq_index_b),
    .expected  (expected_b),
    .err       (err_b),
    .err_count (err_count_b)
  );

  // ---------------- model ----------------
  int seq_tab[11] = '{1, 7, 11, 4, 9, 2, 5, 12, 6, 3, 15};

  typedef struct {
    int mode;  // 0 hunt, 1 verify, 2 locked
    int run;
    int miss;
    int exp_v;
    int idx;
    int err;
    int cnt;
  } model_t;

  model_t ma, mb;

  function automatic int find_pos(input int v);
    int p;
    p = -1;
    for (int i = 0; i < 11; i++) if (seq_tab[i] == v) p = i;
    return p;
  endfunction

  function automatic model_t model_step(input model_t m, input bit rst, input bit valid,
                                        input int data, input bit clr, input int lockm,
                                        input int loss, input int maxcnt);
    model_t n;
    int p;
    bit counted;
    n = m;
    counted = 1'b0;
    if (rst) begin
      n = '{0, 0, 0, 0, 0, 0, 0};
      return n;
    end
    n.err = 0;
    if (valid) begin
      p = find_pos(data);
      case (m.mode)
        0: if (p >= 0) begin
          n.run = 1;
          n.exp_v = seq_tab[(p + 1) % 11];
          if (lockm == 1) begin
            n.mode = 2; n.idx = p; n.miss = 0;
          end else n.mode = 1;
        end
        1: if (p < 0) begin
          n.mode = 0; n.exp_v = 0; n.run = 0;
        end else if (data == m.exp_v) begin
          n.run = m.run + 1;
          n.exp_v = seq_tab[(p + 1) % 11];
          if (n.run == lockm) begin
            n.mode = 2; n.idx = p; n.miss = 0;
          end
        end else begin
          n.run = 1;
          n.exp_v = seq_tab[(p + 1) % 11];
        end
        default: if (data == m.exp_v) begin
          n.idx = p; n.exp_v = seq_tab[(p + 1) % 11]; n.miss = 0;
        end else begin
          n.err = 1;
          counted = 1'b1;
          n.miss = m.miss + 1;
          if (n.miss == loss) begin
            n.mode = 0; n.idx = 0; n.exp_v = 0; n.miss = 0; n.run = 0;
          end else begin
            n.idx = (m.idx + 1) % 11;
            n.exp_v = seq_tab[(n.idx + 1) % 11];
          end
        end
      endcase
    end
    if (clr) n.cnt = counted ? 1 : 0;
    else if (counted && m.cnt < maxcnt) n.cnt = m.cnt + 1;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    ma = model_step(ma, reset, in_valid, int'(in_data), clear_err, 3, 2, 255);
    mb = model_step(mb, reset, in_valid, int'(in_data), clear_err, 1, 15, 3);
    if (reset) started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("a.locked", 32'(locked_a), 32'(ma.mode == 2));
      chk("a.seq_index", 32'(seq_index_a), ma.idx);
      chk("a.expected", 32'(expected_a), ma.exp_v);
      chk("a.err", 32'(err_a), ma.err);
      chk("a.err_count", 32'(err_count_a), ma.cnt);
      chk("b.locked", 32'(locked_b), 32'(mb.mode == 2));
      chk("b.seq_index", 32'(seq_index_b), mb.idx);
      chk("b.expected", 32'(expected_b), mb.exp_v);
      chk("b.err", 32'(err_b), mb.err);
      chk("b.err_count", 32'(err_count_b), mb.cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic feed(input int v, input bit clr = 1'b0);
    in_valid  = 1'b1;
    in_data   = 4'(v);
    clear_err = clr;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    clear_err = 1'b0;
  endtask

  initial begin
    int wrap_vals[5];
    int wrap_idx[5];
    wrap_vals = '{6, 3, 15, 1, 7};
    wrap_idx  = '{8, 9, 10, 0, 1};
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 4'd0;
    clear_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.locked", 32'(locked_a), 0);
    chk("rst.expected", 32'(expected_a), 0);
    chk("rst.err_count", 32'(err_count_a), 0);
    reset = 1'b0;

    // Acquire lock on A.
    feed(1);
    feed(7);  chk("lock.after7", 32'(locked_a), 0);
    feed(11); chk("lock.after11", 32'(locked_a), 1);
    chk("lock.idx11", 32'(seq_index_a), 2);
    feed(4);  chk("lock.idx4", 32'(seq_index_a), 3);
    chk("lock.exp4", 32'(expected_a), 9);

    // Single mismatch with flywheel, then resync.
    feed(13);
    chk("mis.err", 32'(err_a), 1);
    chk("mis.cnt", 32'(err_count_a), 1);
    chk("mis.exp", 32'(expected_a), 2);
    chk("mis.locked", 32'(locked_a), 1);
    feed(2);
    feed(5);  chk("mis.idx5", 32'(seq_index_a), 6);
    chk("mis.locked5", 32'(locked_a), 1);
    feed(12); chk("run.idx12", 32'(seq_index_a), 7);

    // Wrap-around 15 -> 1.
    for (int i = 0; i < 5; i++) begin
      feed(wrap_vals[i]);
      chk("wrap.idx", 32'(seq_index_a), wrap_idx[i]);
      chk("wrap.err", 32'(err_a), 0);
    end

    // Two mismatches drop lock.
    feed(8);  chk("loss.err1", 32'(err_a), 1);
    feed(0);  chk("loss.err2", 32'(err_a), 1);
    chk("loss.locked", 32'(locked_a), 0);
    chk("loss.exp", 32'(expected_a), 0);
    chk("loss.cnt", 32'(err_count_a), 3);

    // Hunt edges.
    feed(0);  feed(10);
    chk("hunt.locked", 32'(locked_a), 0);
    chk("hunt.exp", 32'(expected_a), 0);
    feed(2);  chk("hunt.exp2", 32'(expected_a), 5);
    feed(5);  chk("hunt.exp5", 32'(expected_a), 12);
    feed(9);  chk("hunt.restart", 32'(expected_a), 2);
    feed(2);  chk("hunt.nolock", 32'(locked_a), 0);
    feed(5);  chk("hunt.locked5", 32'(locked_a), 1);
    chk("hunt.idx5", 32'(seq_index_a), 6);

    // Saturation and clear on B (LOCK_MATCHES=1, LOSS_ERRORS=15, 2-bit count).
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    feed(1);  chk("b.lock1", 32'(locked_b), 1);
    for (int i = 0; i < 4; i++) feed(0);
    chk("b.sat", 32'(err_count_b), 3);
    chk("b.still_locked", 32'(locked_b), 1);
    feed(0, 1'b1);
    chk("b.clr_mis", 32'(err_count_b), 1);
    chk("b.clr_err", 32'(err_b), 1);
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err = 1'b0;
    chk("b.clr_only", 32'(err_count_b), 0);
    feed(5);  chk("b.resync", 32'(seq_index_b), 6);

    // Reset mid-lock with a valid sample present.
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 4'd12;
    @(posedge clk); #1;
    chk("b.rst.locked", 32'(locked_b), 0);
    chk("b.rst.idx", 32'(seq_index_b), 0);
    chk("b.rst.exp", 32'(expected_b), 0);
    chk("b.rst.cnt", 32'(err_count_b), 0);
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
